// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO: queues CPU writes and serialises them 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit, giving 8E1 frames.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned PTR_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             ovf_clr,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic [PTR_W:0]   level,
    output logic             ovf,
    output logic             TX
);

    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             push;
    logic             pop;
    logic             baud_end;
    logic [7:0]       head;

    assign head     = mem_q[rd_ptr_q];
    assign baud_end = (cnt_q == CNT_LAST);

    // The FSM consumes the head only when leaving IDLE or at the end of a stop bit.
    always_comb begin
        pop = 1'b0;
        if (!empty_q) begin
            if (state_q == IDLE)
                pop = 1'b1;
            else if (state_q == STOP && baud_end)
                pop = 1'b1;
        end
    end

    always_comb begin
        push     = wr_en && !full_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + (PTR_W + 1)'(1);
        else if (!push && pop)
            level_d = level_q - (PTR_W + 1)'(1);
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
        ovf_d   = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (wr_en && full_q)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q  <= START;
                        shift_q  <= head;
                        cnt_q    <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                    end
                end
                START: begin
                    if (baud_end) begin
                        state_q   <= DATA;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        cnt_q <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (pop) begin
                            state_q  <= START;
                            shift_q  <= head;
                            tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^head;
`endif
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = busy_q;
    assign level = level_q;
    assign ovf   = ovf_q;
    assign TX    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table for FIFO/flag behaviour, hand sequences for framing and corners.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic          busy;
    logic [PW:0]   level;
    logic          ovf;
    logic          TX;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .PTR_W       (PW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .ovf_clr(ovf_clr),
        .full   (full),
        .empty  (empty),
        .busy   (busy),
        .level  (level),
        .ovf    (ovf),
        .TX     (TX)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       clr;
        int         lvl;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       busy;
        logic       tx;
    } vec_t;

    vec_t vecs[15];
    logic exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level per clock for one frame: start, data LSB first, [even parity], stop.
    task automatic add_frame(input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic set_vec(input int i, input logic r, input logic w, input logic [7:0] d,
                           input logic c, input int l, input logic f, input logic e,
                           input logic o, input logic b, input logic t);
        vecs[i].rst = r;  vecs[i].wr = w;    vecs[i].d = d;     vecs[i].clr = c;
        vecs[i].lvl = l;  vecs[i].full = f;  vecs[i].empty = e; vecs[i].ovf = o;
        vecs[i].busy = b; vecs[i].tx = t;
    endtask

    initial begin
        int toggles;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;

        // rst wr data clr | lvl full empty ovf busy tx
        set_vec( 0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1);
        set_vec( 1, 0, 1, 8'h11, 0, 1, 0, 0, 0, 0, 1);
        set_vec( 2, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        set_vec( 3, 0, 1, 8'h21, 0, 1, 0, 0, 0, 1, 0);
        set_vec( 4, 0, 1, 8'h22, 0, 2, 0, 0, 0, 1, 0);
        set_vec( 5, 0, 1, 8'h23, 0, 3, 0, 0, 0, 1, 0);
        set_vec( 6, 0, 1, 8'h24, 0, 4, 0, 0, 0, 1, 1);
        set_vec( 7, 0, 1, 8'h25, 0, 5, 0, 0, 0, 1, 1);
        set_vec( 8, 0, 1, 8'h26, 0, 6, 0, 0, 0, 1, 1);
        set_vec( 9, 0, 1, 8'h27, 0, 7, 0, 0, 0, 1, 1);
        set_vec(10, 0, 1, 8'h28, 0, 8, 1, 0, 0, 1, 0);
        set_vec(11, 0, 1, 8'h29, 0, 8, 1, 0, 1, 1, 0);
        set_vec(12, 0, 1, 8'h2A, 1, 8, 1, 0, 1, 1, 0);
        set_vec(13, 0, 0, 8'h00, 1, 8, 1, 0, 0, 1, 0);
        set_vec(14, 0, 0, 8'h00, 0, 8, 1, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; wr_en = vecs[i].wr; wr_data = vecs[i].d; ovf_clr = vecs[i].clr;
            tick;
            chk($sformatf("v%0d.level", i), int'(level), vecs[i].lvl);
            chk($sformatf("v%0d.full",  i), int'(full),  int'(vecs[i].full));
            chk($sformatf("v%0d.empty", i), int'(empty), int'(vecs[i].empty));
            chk($sformatf("v%0d.ovf",   i), int'(ovf),   int'(vecs[i].ovf));
            chk($sformatf("v%0d.busy",  i), int'(busy),  int'(vecs[i].busy));
            chk($sformatf("v%0d.tx",    i), int'(TX),    int'(vecs[i].tx));
        end
        rst = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0;

        // Single frame 0x55 from IDLE.
        do_reset;
        exp_q = {};
        add_frame(8'h55);
        wr_en = 1'b1; wr_data = 8'h55;
        tick;
        wr_en = 1'b0;
        chk("f55.tx_at_write", int'(TX), 1);
        chk("f55.level_at_write", int'(level), 1);
        for (int i = 0; i < FRAME_CYC; i++) begin
            tick;
            chk($sformatf("f55.tx[%0d]", i), int'(TX), int'(exp_q[i]));
        end
        chk("f55.busy_during_stop", int'(busy), 1);
        tick;
        chk("f55.busy_after", int'(busy), 0);
        chk("f55.tx_after", int'(TX), 1);

        // Back-to-back frames 0xA3, 0x0F.
        do_reset;
        exp_q = {};
        add_frame(8'hA3);
        add_frame(8'h0F);
        wr_en = 1'b1; wr_data = 8'hA3;
        tick;
        chk("b2b.level0", int'(level), 1);
        wr_data = 8'h0F;
        tick;
        wr_en = 1'b0;
        chk("b2b.tx[0]", int'(TX), int'(exp_q[0]));
        chk("b2b.level1", int'(level), 1);
        for (int i = 1; i < 2 * FRAME_CYC; i++) begin
            tick;
            chk($sformatf("b2b.tx[%0d]", i), int'(TX), int'(exp_q[i]));
            if (i == FRAME_CYC) chk("b2b.level2", int'(level), 0);
            if (i == FRAME_CYC) chk("b2b.busy_mid", int'(busy), 1);
        end
        tick;
        chk("b2b.busy_after", int'(busy), 0);

        // Reset in the middle of data bit 3 of 0x37 with another byte queued.
        do_reset;
        exp_q = {};
        add_frame(8'h37);
        wr_en = 1'b1; wr_data = 8'h37;
        tick;
        wr_data = 8'h99;
        tick;
        wr_en = 1'b0;
        for (int i = 1; i <= 16 + CPB / 2; i++) begin
            tick;
            chk($sformatf("rst.tx[%0d]", i), int'(TX), int'(exp_q[i]));
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst.tx", int'(TX), 1);
        chk("rst.empty", int'(empty), 1);
        chk("rst.level", int'(level), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.full", int'(full), 0);
        toggles = 0;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            tick;
            if (TX !== 1'b1) toggles++;
        end
        chk("rst.tx_quiet", toggles, 0);

        // Write at full on the same edge as the STOP->START pop.
        do_reset;
        exp_q = {};
        add_frame(8'hB1);
        wr_en = 1'b1; wr_data = 8'hC0;
        tick;
        for (int k = 1; k <= 8; k++) begin
            wr_data = 8'hB0 + 8'(k);
            tick;
        end
        wr_en = 1'b0;
        chk("stopfull.level_filled", int'(level), 8);
        chk("stopfull.full_filled", int'(full), 1);
        for (int t = 9; t <= FRAME_CYC; t++) tick;
        chk("stopfull.level_pre", int'(level), 8);
        chk("stopfull.tx_stop", int'(TX), 1);
        chk("stopfull.ovf_pre", int'(ovf), 0);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick;
        wr_en = 1'b0;
        chk("stopfull.level", int'(level), 7);
        chk("stopfull.full", int'(full), 0);
        chk("stopfull.ovf", int'(ovf), 1);
        chk("stopfull.tx_start", int'(TX), 0);
        for (int i = 1; i < FRAME_CYC; i++) begin
            tick;
            chk($sformatf("stopfull.b1[%0d]", i), int'(TX), int'(exp_q[i]));
        end

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight -> parity 1; 0x03 -> parity 0.
        do_reset;
        exp_q = {};
        add_frame(8'h07);
        wr_en = 1'b1; wr_data = 8'h07;
        tick;
        wr_en = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            tick;
            chk($sformatf("p07.tx[%0d]", i), int'(TX), int'(exp_q[i]));
            if (i == 9 * CPB) chk("p07.parity_bit", int'(TX), 1);
        end
        tick;
        chk("p07.busy_after", int'(busy), 0);
        do_reset;
        exp_q = {};
        add_frame(8'h03);
        wr_en = 1'b1; wr_data = 8'h03;
        tick;
        wr_en = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            tick;
            chk($sformatf("p03.tx[%0d]", i), int'(TX), int'(exp_q[i]));
            if (i == 9 * CPB) chk("p03.parity_bit", int'(TX), 0);
        end
        tick;
        chk("p03.busy_after", int'(busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
